max7219_frame_sequencer: RTL
============================

Name: max7219_frame_sequencer

Overview:
- Controller that owns the SPI master driving the MAX7219 display and schedules every 16-bit word sent to it.
- After reset it sends a fixed init sequence.
- On each rising edge of the divided 100 Hz clock, while display is enabled, it snapshots the six stopwatch digits and sends them as one consistent frame.
- Sits between the counter chain/controller outputs and the SPI master. Replaces ad-hoc sequencing in the top level.

Parameters:
- INTENSITY, 8, 4-bit brightness value written to register 0xA during init.
- SCAN_LIMIT, 5, value written to register 0xB (digits 0..5 scanned).
- GAP_CYCLES, 32, idle clk cycles between cs_n release and the next word; range 1..255.
- REINIT_FRAMES, 0, re-run init after this many completed frames; 0 = never.

Ports:
- clk  in  1  system clock (1 MHz)
- rst_n  in  1  reset; asynchronous, active-low
- tick  in  1  divided 100 Hz clock (level); rising edge requests a frame
- ena  in  1  display enable (lap freeze when low)
- ces_0X  in  4  centiseconds, units
- ces_X0  in  4  centiseconds, tens
- sec_0X  in  4  seconds, units
- sec_X0  in  3  seconds, tens
- min_0X  in  4  minutes, units
- min_X0  in  3  minutes, tens
- spi_ready  in  1  master idle and ready; valid while cs_n high
- spi_sent  in  1  master finished shifting the word; valid while cs_n low
- cs_n  out  1  chip select to master/display, active-low
- word  out  16  word to master: {4'h0, addr[3:0], data[7:0]}
- busy  out  1  high in any state other than IDLE
- frame_done  out  1  one-cycle pulse when last digit word released
- overrun  out  1  one-cycle pulse when a tick edge arrives while not IDLE

Behaviour:
- Reset values: cs_n=1, word=16'h0000, busy=1, frame_done=0, overrun=0, state=INIT_LOAD, init index=0, tick_q=0, frame count=0.
- Rising-edge detect: tick_rise = tick & ~tick_q, where tick_q is tick registered on clk.
- States: INIT_LOAD, IDLE, LOAD, SEND, RELEASE, GAP.
- Init words, in order:
  - 0x0F00 (display test off)
  - 0x0C01 (shutdown off)
  - 0x0B00|SCAN_LIMIT
  - 0x0A00|INTENSITY
  - 0x09FF (BCD decode all)
- Frame words, in order: addr 1..6 = ces_0X, ces_X0, sec_0X|0x80 (decimal point), sec_X0, min_0X|0x80, min_X0. Zero-extend digit values to 8 bits.
- INIT_LOAD/LOAD: drive word from the init table or the snapshot at the current index, then go to SEND. This takes one cycle.
- SEND:
  - Wait for spi_ready=1 with cs_n still high.
  - Then drive cs_n=0. word must be held stable from this point until cs_n returns high.
  - Stay in SEND until spi_sent=1.
- RELEASE:
  - Drive cs_n=1 in the cycle after spi_sent is seen.
  - Wait for spi_ready=1, then go to GAP.
- GAP:
  - Count GAP_CYCLES cycles.
  - Then, if words remain in the current sequence, advance the index and go to LOAD.
  - If init has ended, go to IDLE.
  - If a frame has ended, pulse frame_done and go to IDLE.
- IDLE, on tick_rise & ena:
  - Snapshot all six digit inputs into internal registers in the same cycle.
  - Set index=0 and go to LOAD.
  - The bus never shows a mixed frame; digit input changes after the snapshot are ignored until the next frame.
- tick_rise while not IDLE: the tick is dropped, overrun pulses, and no frame is queued.
- ena low: no new frames start. A frame already in progress completes. The display keeps its last frame (lap time).
- REINIT_FRAMES>0: after frame_done on frame number REINIT_FRAMES, go to INIT_LOAD instead of IDLE, then reset the frame count. The frame counter wraps to 0 at the limit.
- Reset mid-word: cs_n goes high asynchronously and init restarts from index 0. A partial word is never resumed.
- Latency: tick_rise to first cs_n fall is 3 cycles when spi_ready is already high.

Optional Feature:
- Macro: FRAME_SKIP_UNCHANGED_EN.
- When defined:
  - In LOAD, any digit word equal to the word last sent to the same address is skipped; the index advances with no SEND, RELEASE or GAP.
  - The last-sent cache is invalidated by init, so the first frame after init is always sent in full.
  - frame_done still pulses, including for a frame with zero words sent.
- When undefined: all six digit words are sent every frame.

Test Plan:
- Reset release, with the master model responding to spi_ready/spi_sent -> exactly 5 words 0x0F00, 0x0C01, 0x0B05, 0x0A08, 0x09FF, each with one cs_n low pulse; then busy=0.
- Digits 5,9,3,2,7,1 (ces_0X..min_X0), tick rises, ena=1 -> words 0x0105, 0x0209, 0x0383, 0x0402, 0x0587, 0x0601, then one frame_done pulse.
- Change the digit inputs one cycle after the snapshot -> transmitted frame still carries the snapshot values.
- Second tick rise during a frame -> overrun pulses once; exactly 6 words sent, no second frame queued.
- ena=0 then tick rises -> no cs_n activity. ena drops mid-frame -> the frame completes all 6 words.
- Assert rst_n low while cs_n=0 -> cs_n=1 the same cycle. After release, the init sequence restarts with 0x0F00.
- With FRAME_SKIP_UNCHANGED_EN: two identical ticks -> second frame sends 0 words but frame_done still pulses. Change ces_0X only -> 1 word.

Source files
------------

// File: rtl/max7219_frame_sequencer.sv
// MAX7219 word scheduler: init sequence, then one six-digit frame per tick edge.
// Optional FRAME_SKIP_UNCHANGED_EN drops digit words equal to the last one sent.
module max7219_frame_sequencer #(
  parameter logic [3:0]  INTENSITY     = 4'd8,
  parameter logic [7:0]  SCAN_LIMIT    = 8'd5,
  parameter int unsigned GAP_CYCLES    = 32,
  parameter int unsigned REINIT_FRAMES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        ena,
  input  logic [3:0]  ces_0X,
  input  logic [3:0]  ces_X0,
  input  logic [3:0]  sec_0X,
  input  logic [2:0]  sec_X0,
  input  logic [3:0]  min_0X,
  input  logic [2:0]  min_X0,
  input  logic        spi_ready,
  input  logic        spi_sent,
  output logic        cs_n,
  output logic [15:0] word,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun
);

  typedef enum logic [2:0] {
    INIT_LOAD, IDLE, LOAD, SEND, RELEASE, GAP
  } state_t;

  localparam logic [7:0]  GAP_LD  = 8'(GAP_CYCLES - 1);
  localparam logic [15:0] RF_LAST = 16'(REINIT_FRAMES - 1);

  state_t      state;
  logic [2:0]  idx;
  logic [7:0]  gap_cnt;
  logic [15:0] frm_cnt;
  logic        init_seq;
  logic        tick_q;
  logic        tick_rise;
  logic        reinit_now;

  logic [3:0]  s_c0, s_c1, s_s0, s_m0;
  logic [2:0]  s_s1, s_m1;

  logic [15:0] init_word;
  logic [7:0]  fdata;
  logic [15:0] fword;

  assign tick_rise  = tick & ~tick_q;
  assign reinit_now = (REINIT_FRAMES != 0) && (frm_cnt == RF_LAST);

  always_comb begin
    init_word = 16'h09FF;
    case (idx)
      3'd0:    init_word = 16'h0F00;
      3'd1:    init_word = 16'h0C01;
      3'd2:    init_word = {8'h0B, SCAN_LIMIT};
      3'd3:    init_word = {8'h0A, 4'h0, INTENSITY};
      default: init_word = 16'h09FF;
    endcase
  end

  // Decimal points sit after seconds and minutes units.
  always_comb begin
    fdata = 8'h00;
    case (idx)
      3'd0:    fdata = {4'h0, s_c0};
      3'd1:    fdata = {4'h0, s_c1};
      3'd2:    fdata = {4'h8, s_s0};
      3'd3:    fdata = {5'h00, s_s1};
      3'd4:    fdata = {4'h8, s_m0};
      default: fdata = {5'h00, s_m1};
    endcase
  end

  assign fword = {4'h0, {1'b0, idx} + 4'd1, fdata};

`ifdef FRAME_SKIP_UNCHANGED_EN
  logic [7:0] last_data [6];
  logic [5:0] last_vld;
  logic       skip;

  assign skip = last_vld[idx] && (last_data[idx] == fdata);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= INIT_LOAD;
      idx        <= 3'd0;
      gap_cnt    <= 8'd0;
      frm_cnt    <= 16'd0;
      init_seq   <= 1'b1;
      tick_q     <= 1'b0;
      cs_n       <= 1'b1;
      word       <= 16'h0000;
      busy       <= 1'b1;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      s_c0       <= 4'd0;
      s_c1       <= 4'd0;
      s_s0       <= 4'd0;
      s_s1       <= 3'd0;
      s_m0       <= 4'd0;
      s_m1       <= 3'd0;
`ifdef FRAME_SKIP_UNCHANGED_EN
      last_vld   <= 6'd0;
      for (int i = 0; i < 6; i++) last_data[i] <= 8'h00;
`endif
    end else begin
      tick_q     <= tick;
      frame_done <= 1'b0;
      overrun    <= tick_rise && (state != IDLE);

      unique case (state)
        INIT_LOAD: begin
          init_seq <= 1'b1;
          word     <= init_word;
          state    <= SEND;
`ifdef FRAME_SKIP_UNCHANGED_EN
          last_vld <= 6'd0;
`endif
        end

        IDLE: begin
          if (tick_rise && ena) begin
            s_c0     <= ces_0X;
            s_c1     <= ces_X0;
            s_s0     <= sec_0X;
            s_s1     <= sec_X0;
            s_m0     <= min_0X;
            s_m1     <= min_X0;
            idx      <= 3'd0;
            init_seq <= 1'b0;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end

        LOAD: begin
`ifdef FRAME_SKIP_UNCHANGED_EN
          if (skip) begin
            if (idx != 3'd5) begin
              idx <= idx + 3'd1;
            end else begin
              frame_done <= 1'b1;
              idx        <= 3'd0;
              if (reinit_now) begin
                frm_cnt  <= 16'd0;
                init_seq <= 1'b1;
                state    <= INIT_LOAD;
              end else begin
                frm_cnt <= frm_cnt + 16'd1;
                busy    <= 1'b0;
                state   <= IDLE;
              end
            end
          end else begin
            last_data[idx] <= fdata;
            last_vld[idx]  <= 1'b1;
            word           <= fword;
            state          <= SEND;
          end
`else
          word  <= fword;
          state <= SEND;
`endif
        end

        SEND: begin
          if (cs_n) begin
            if (spi_ready) cs_n <= 1'b0;
          end else if (spi_sent) begin
            cs_n  <= 1'b1;
            state <= RELEASE;
          end
        end

        RELEASE: begin
          if (spi_ready) begin
            gap_cnt <= GAP_LD;
            state   <= GAP;
          end
        end

        GAP: begin
          if (gap_cnt != 8'd0) begin
            gap_cnt <= gap_cnt - 8'd1;
          end else if (init_seq) begin
            if (idx != 3'd4) begin
              idx   <= idx + 3'd1;
              state <= INIT_LOAD;
            end else begin
              idx   <= 3'd0;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else if (idx != 3'd5) begin
            idx   <= idx + 3'd1;
            state <= LOAD;
          end else begin
            frame_done <= 1'b1;
            idx        <= 3'd0;
            if (reinit_now) begin
              frm_cnt  <= 16'd0;
              init_seq <= 1'b1;
              state    <= INIT_LOAD;
            end else begin
              frm_cnt <= frm_cnt + 16'd1;
              busy    <= 1'b0;
              state   <= IDLE;
            end
          end
        end

        default: state <= INIT_LOAD;
      endcase
    end
  end

endmodule
